// File: rtl/associative_buffer_arbiter.sv
// associative_buffer_arbiter: round-robin sharing of one associative buffer among NUM_REQ requesters.
// Define ABUF_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module associative_buffer_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int KEY_WIDTH  = 2,
  parameter int DATA_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [2*NUM_REQ-1:0]          req_cmd,
  input  logic [KEY_WIDTH*NUM_REQ-1:0]  req_key,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            done,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_hit,
  output logic                          busy,
  output logic [1:0]                    buf_ctrl,
  output logic [KEY_WIDTH-1:0]          buf_key,
  output logic [DATA_WIDTH-1:0]         buf_data,
  input  logic [DATA_WIDTH-1:0]         buf_data_output,
  input  logic                          buf_valid
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam logic [1:0] S_IDLE = 2'd0, S_ISSUE = 2'd1, S_SETTLE = 2'd2, S_RESP = 2'd3;
  localparam logic [NUM_REQ-1:0] ONE = 1;
  logic [1:0]    state;
  logic [IW-1:0] win, cur;
  int            idx;
`ifndef ABUF_ARB_FIXED_PRIO_EN
  logic [IW-1:0] rr;
`endif
  // Scan downward so the last hit is the first set bit at or after the start point.
  always_comb begin
    win = '0;
    idx = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
`ifdef ABUF_ARB_FIXED_PRIO_EN
      idx = k;
`else
      idx = (int'(rr) + k) % NUM_REQ;
`endif
      if (req[idx]) win = idx[IW-1:0];
    end
  end
  // READ and NONE share encoding 0, so the latched command drives buf_ctrl directly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cur      <= '0;
      gnt      <= '0;
      done     <= '0;
      rsp_data <= '0;
      rsp_hit  <= 1'b0;
      busy     <= 1'b0;
      buf_ctrl <= 2'd0;
      buf_key  <= '0;
      buf_data <= '0;
`ifndef ABUF_ARB_FIXED_PRIO_EN
      rr       <= '0;
`endif
    end else begin
      done     <= '0;
      buf_ctrl <= 2'd0;
      case (state)
        S_IDLE: if (|req) begin
          cur      <= win;
          gnt      <= ONE << win;
          buf_ctrl <= req_cmd[2*win +: 2];
          buf_key  <= req_key[KEY_WIDTH*win +: KEY_WIDTH];
          buf_data <= req_data[DATA_WIDTH*win +: DATA_WIDTH];
          busy     <= 1'b1;
          state    <= S_ISSUE;
        end
        S_ISSUE: state <= S_SETTLE;
        S_SETTLE: begin
          rsp_data <= buf_data_output;
          rsp_hit  <= buf_valid;
          done     <= ONE << cur;
          state    <= S_RESP;
        end
        default: begin
          gnt   <= '0;
          busy  <= 1'b0;
          state <= S_IDLE;
`ifndef ABUF_ARB_FIXED_PRIO_EN
          rr    <= (int'(cur) == NUM_REQ - 1) ? '0 : cur + 1'b1;
`endif
        end
      endcase
    end
  end
endmodule

// File: tb/tb_associative_buffer_arbiter.sv
// tb_associative_buffer_arbiter: directed bench with a small keyed-buffer model behind the arbiter.
module tb_associative_buffer_arbiter;
  logic clk = 1'b0, rst = 1'b0;
  logic [3:0] req = '0;
  logic [7:0] req_cmd = '0, req_key = '0;
  logic [15:0] req_data = '0;
  logic [3:0] gnt, done, rsp_data, buf_data, bdo;
  logic rsp_hit, busy, bv;
  logic [1:0] buf_ctrl, buf_key;
  logic [3:0] mem [4];
  logic [3:0] vld;
  int checks = 0, failures = 0;

  associative_buffer_arbiter #(.NUM_REQ(4), .KEY_WIDTH(2), .DATA_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .req(req), .req_cmd(req_cmd), .req_key(req_key), .req_data(req_data),
    .gnt(gnt), .done(done), .rsp_data(rsp_data), .rsp_hit(rsp_hit), .busy(busy),
    .buf_ctrl(buf_ctrl), .buf_key(buf_key), .buf_data(buf_data),
    .buf_data_output(bdo), .buf_valid(bv)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) mem[k] <= '0;
      vld <= '0;
    end else if (buf_ctrl == 2'd1) begin
      for (int k = 0; k < 4; k++) mem[k] <= '0;
      vld <= '0;
    end else if (buf_ctrl == 2'd2) begin
      mem[buf_key] <= buf_data;
      vld[buf_key] <= 1'b1;
    end else if (buf_ctrl == 2'd3) mem[buf_key] <= mem[buf_key] + 4'd1;
  end
  assign bdo = mem[buf_key];
  assign bv  = vld[buf_key];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    req = '0;
    tick;
    tick;
    rst = 1'b1;
  endtask

  task automatic txn(input int i, input logic [1:0] cmd, input logic [1:0] key, input logic [3:0] d,
                     input logic [3:0] exp_d, input logic exp_h, input string name);
    req_cmd[2*i +: 2] = cmd;
    req_key[2*i +: 2] = key;
    req_data[4*i +: 4] = d;
    req[i] = 1'b1;
    tick;
    req[i] = 1'b0;
    checks++;
    if (buf_ctrl !== cmd || gnt !== (4'b1 << i) || busy !== 1'b1 || buf_key !== key) begin
      failures++;
      $display("FAIL %s_issue: ctrl=%0d gnt=%b busy=%b key=%b, need ctrl=%0d gnt=%b busy=1 key=%b",
               name, buf_ctrl, gnt, busy, buf_key, cmd, 4'b1 << i, key);
    end
    tick;
    checks++;
    if (buf_ctrl !== 2'd0 || done !== 4'b0) begin
      failures++;
      $display("FAIL %s_settle: ctrl=%0d done=%b, need ctrl=0 done=0000", name, buf_ctrl, done);
    end
    tick;
    checks++;
    if (done !== (4'b1 << i) || rsp_data !== exp_d || rsp_hit !== exp_h || buf_ctrl !== 2'd0) begin
      failures++;
      $display("FAIL %s_resp: done=%b data=%b hit=%b ctrl=%0d, need done=%b data=%b hit=%b ctrl=0",
               name, done, rsp_data, rsp_hit, buf_ctrl, 4'b1 << i, exp_d, exp_h);
    end
    tick;
    checks++;
    if (done !== 4'b0 || gnt !== 4'b0 || busy !== 1'b0 || rsp_data !== exp_d) begin
      failures++;
      $display("FAIL %s_idle: done=%b gnt=%b busy=%b data=%b, need 0000 0000 0 %b",
               name, done, gnt, busy, rsp_data, exp_d);
    end
  endtask

  task automatic test_reset;
    do_reset;
    checks++;
    if ({gnt, done, rsp_data, rsp_hit, busy, buf_ctrl, buf_key, buf_data} !== 23'b0) begin
      failures++;
      $display("FAIL reset: gnt=%b done=%b data=%b hit=%b busy=%b ctrl=%0d key=%b bdata=%b, need all 0",
               gnt, done, rsp_data, rsp_hit, busy, buf_ctrl, buf_key, buf_data);
    end
  endtask

  task automatic test_load_read;
    txn(1, 2'd2, 2'b01, 4'b1110, 4'b1110, 1'b1, "load");
    txn(1, 2'd0, 2'b01, 4'b0000, 4'b1110, 1'b1, "read_after_load");
  endtask

  task automatic test_incr;
    txn(2, 2'd3, 2'b01, 4'b0000, 4'b1111, 1'b1, "incr");
    txn(2, 2'd0, 2'b01, 4'b0000, 4'b1111, 1'b1, "read_after_incr");
  endtask

  task automatic test_clr;
    txn(0, 2'd1, 2'b10, 4'b0000, 4'b0000, 1'b0, "clr");
    txn(0, 2'd0, 2'b10, 4'b0000, 4'b0000, 1'b0, "read_after_clr");
    txn(0, 2'd0, 2'b01, 4'b0000, 4'b0000, 1'b0, "read_cleared_key");
  endtask

  task automatic test_back_to_back;
    int seq[$], cyc[$];
    int exp_seq[5];
`ifdef ABUF_ARB_FIXED_PRIO_EN
    exp_seq = '{0, 0, 0, 0, 0};
`else
    exp_seq = '{0, 1, 2, 3, 0};
`endif
    do_reset;
    req_cmd = '0;
    req = 4'hF;
    for (int c = 1; c <= 20; c++) begin
      tick;
      checks++;
      if (busy ? !$onehot(gnt) : (gnt !== 4'b0)) begin
        failures++;
        $display("FAIL b2b_gnt_onehot: cycle %0d gnt=%b busy=%b, need one-hot while busy", c, gnt, busy);
      end
      if (done !== 4'b0)
        for (int j = 0; j < 4; j++) if (done[j]) begin seq.push_back(j); cyc.push_back(c); end
    end
    req = '0;
    tick;
    tick;
    tick;
    checks++;
    if (seq.size() != 5) begin
      failures++;
      $display("FAIL b2b_count: got %0d done pulses, need 5", seq.size());
    end else
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (seq[k] != exp_seq[k] || cyc[k] != 3 + 4 * k) begin
          failures++;
          $display("FAIL b2b_order: pulse %0d req=%0d cycle=%0d, need req=%0d cycle=%0d",
                   k, seq[k], cyc[k], exp_seq[k], 3 + 4 * k);
        end
      end
  endtask

  task automatic test_abort;
    do_reset;
    txn(2, 2'd0, 2'b00, 4'b0000, 4'b0000, 1'b0, "abort_prep");
    req_cmd[3:2] = 2'd2;
    req_key[3:2] = 2'b11;
    req_data[7:4] = 4'b0101;
    req[1] = 1'b1;
    tick;
    req[1] = 1'b0;
    tick;
    rst = 1'b0;
    #1;
    checks++;
    if ({gnt, done, rsp_data, rsp_hit, busy, buf_ctrl, buf_key, buf_data} !== 23'b0) begin
      failures++;
      $display("FAIL abort_async: gnt=%b done=%b busy=%b ctrl=%0d key=%b bdata=%b, need all 0",
               gnt, done, busy, buf_ctrl, buf_key, buf_data);
    end
    tick;
    tick;
    checks++;
    if (done !== 4'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_done: done=%b busy=%b, need 0000 0", done, busy);
    end
    rst = 1'b1;
    req_cmd = '0;
    req = 4'b1001;
    tick;
    req = '0;
    checks++;
    if (gnt !== 4'b0001) begin
      failures++;
      $display("FAIL abort_regrant: gnt=%b, need 0001", gnt);
    end
    tick;
    tick;
    tick;
  endtask

  task automatic test_fairness;
    int seq[$];
    int n3;
    int exp_seq[5];
`ifdef ABUF_ARB_FIXED_PRIO_EN
    exp_seq = '{0, 0, 0, 0, 0};
`else
    exp_seq = '{0, 3, 0, 3, 0};
`endif
    n3 = 0;
    do_reset;
    req_cmd = '0;
    req = 4'b1001;
    for (int c = 1; c <= 20; c++) begin
      tick;
      for (int j = 0; j < 4; j++) if (done[j]) seq.push_back(j);
      if (done[3]) n3++;
    end
    req = '0;
    tick;
    tick;
    tick;
    checks++;
    if (seq.size() != 5) begin
      failures++;
      $display("FAIL fair_count: got %0d done pulses, need 5", seq.size());
    end else
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (seq[k] != exp_seq[k]) begin
          failures++;
          $display("FAIL fair_order: pulse %0d req=%0d, need req=%0d", k, seq[k], exp_seq[k]);
        end
      end
    checks++;
`ifdef ABUF_ARB_FIXED_PRIO_EN
    if (n3 != 0) begin
`else
    if (n3 != 2) begin
`endif
      failures++;
      $display("FAIL fair_req3: done[3] pulses=%0d, need %0d", n3, exp_seq[1] == 3 ? 2 : 0);
    end
  endtask

  initial begin
    test_reset;
    test_load_read;
    test_incr;
    test_clr;
    test_back_to_back;
    test_abort;
    test_fairness;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
